// File: rtl/bcd7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd7_pkg
//  Description : Shared BCD constants and the BCD to 7-segment encoder used by
//                the multi-digit up/down counter and its display driver.
//                Segment bit order is {g,f,e,d,c,b,a}, active-high.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd7_pkg;

    // Largest legal value of a single decade
    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-BCD codes render as "0" so a corrupted digit never lights garbage
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_0;
        endcase
    endfunction

endpackage : bcd7_pkg
`default_nettype wire

// File: rtl/bcd_decade.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_decade
//  Description : Combinational next-state logic for one BCD decade. When
//                step_in is high the digit moves one step in the direction
//                given by up_dn; step_out flags the carry (9->0) or borrow
//                (0->9) into the next decade.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_decade
    import bcd7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       up_dn,
    input  logic       step_in,
    output logic [3:0] next_digit,
    output logic       step_out
);

    // Single-step BCD increment/decrement with carry/borrow generation
    always_comb begin
        next_digit = digit;
        step_out   = 1'b0;
        if (step_in) begin
            if (up_dn) begin
                if (digit >= BCD_MAX) begin
                    next_digit = 4'd0;
                    step_out   = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    next_digit = BCD_MAX;
                    step_out   = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule : bcd_decade
`default_nettype wire

// File: rtl/bcd_updown_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_updown_display
//  Description : N-decade BCD up/down counter with enable, synchronous
//                parallel load and a one-cycle terminal-count pulse, plus a
//                time-multiplexed 7-segment scan driver with optional
//                leading-zero blanking. All state lives here; each decade's
//                next value comes from a combinational bcd_decade instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_display
    import bcd7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int COMMON_ANODE = 0,
    parameter int BLANK_LZ     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tc,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_pre_w = $clog2(SCAN_DIV);

    localparam logic [c_pre_w-1:0]    c_pre_last  = c_pre_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_digit0 = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] c_an_inv    = (COMMON_ANODE != 0) ? '1 : '0;
    localparam logic [6:0]            c_seg_inv   = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

    logic [4*NUM_DIGITS-1:0] r_count;
    logic [4*NUM_DIGITS-1:0] w_next_count;
    logic [4*NUM_DIGITS-1:0] w_load_clamped;
    logic                    r_tc;
    logic                    w_wrap;
    logic [c_pre_w-1:0]      r_pre;
    logic [c_idx_w-1:0]      r_idx;
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic                    w_zero_acc;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;

    // Ripple chain of decades; each block owns its own step signals so the
    // carry path never loops back through a shared vector.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_decade
        logic       w_step_in;
        logic       w_step_out;
        logic [3:0] w_digit_next;

        if (k == 0) begin : g_lsd
            assign w_step_in = 1'b1;
        end else begin : g_chain
            assign w_step_in = g_decade[k-1].w_step_out;
        end

        bcd_decade u_decade (
            .digit      (r_count[4*k +: 4]),
            .up_dn      (up_dn),
            .step_in    (w_step_in),
            .next_digit (w_digit_next),
            .step_out   (w_step_out)
        );

        assign w_next_count[4*k +: 4]   = w_digit_next;
        // Out-of-range load digits are forced to 0 so the count stays BCD
        assign w_load_clamped[4*k +: 4] = (load_val[4*k +: 4] > BCD_MAX) ? 4'd0
                                                                         : load_val[4*k +: 4];
    end

    // A carry/borrow out of the top decade means the whole count wrapped
    assign w_wrap = g_decade[NUM_DIGITS-1].w_step_out;

    // Count and terminal-count registers: reset > load > enable > hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_next_count;
            r_tc    <= w_wrap;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    // Free-running scan prescaler and digit index, independent of counting
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_pre_last) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // w_zero_from[k] is high when digit k and every digit above it are zero
    always_comb begin
        w_zero_from = '0;
        w_zero_acc  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_from[k] = w_zero_acc && (r_count[4*k +: 4] == 4'd0);
            w_zero_acc     = w_zero_from[k];
        end
    end

    // Select the scanned digit, build its one-hot strobe and segment pattern
    always_comb begin
        w_an  = '0;
        w_seg = SEG_0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_an[k] = 1'b1;
                if ((BLANK_LZ != 0) && (k > 0) && w_zero_from[k]) begin
                    w_seg = SEG_BLANK;
                end else begin
                    w_seg = bcd_to_seg(r_count[4*k +: 4]);
                end
            end
        end
    end

    // Display pins are registered so an and seg always switch together
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_an  <= c_an_digit0 ^ c_an_inv;
            r_seg <= SEG_0 ^ c_seg_inv;
        end else begin
            r_an  <= w_an ^ c_an_inv;
            r_seg <= w_seg ^ c_seg_inv;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule : bcd_updown_display
`default_nettype wire

// File: tb/tb_bcd_updown_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_updown_display
//  Description : Self-checking bench for bcd_updown_display (2 digits, scan
//                divider 4). A common-cathode and a common-anode instance
//                share all inputs. Table-driven counter vectors plus
//                hand-written reset, wrap, scan and mid-count reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_display;

    localparam int ND = 2;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          up_dn;
    logic          load;
    logic [4*ND-1:0] load_val;

    logic [4*ND-1:0] count, count_ca;
    logic            tc, tc_ca;
    logic [ND-1:0]   an, an_ca;
    logic [6:0]      seg, seg_ca;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [10];

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       up_dn;
        logic       load;
        logic [7:0] load_val;
        logic [7:0] exp_count;
        logic       exp_tc;
    } vec_t;

    vec_t vecs [23];

    bcd_updown_display #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .COMMON_ANODE(0), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .an(an), .seg(seg)
    );

    bcd_updown_display #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .COMMON_ANODE(1), .BLANK_LZ(1)
    ) dut_ca (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count_ca), .tc(tc_ca), .an(an_ca), .seg(seg_ca)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        logic [7:0] prev;
        logic [1:0] exp_an, exp_an_n;
        logic [6:0] exp_seg, exp_seg_n;
        logic [3:0] digit;
        int         idx;

        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110;
        seg_tab[2] = 7'b1011011; seg_tab[3] = 7'b1001111;
        seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111;
        seg_tab[8] = 7'b1111111; seg_tab[9] = 7'b1100111;

        //           rst_n  en    up_dn load  load_val exp_cnt tc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h05, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h06, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h06, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h3F, 8'h30, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h29, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h30, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hAB, 8'h00, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h19, 8'h19, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};

        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

        // Reset state after two reset edges
        tick;
        tick;
        check("rst_count", count, 8'h00);
        check("rst_tc", tc, 1'b0);
        check("rst_an", an, 2'b01);
        check("rst_seg", seg, 7'b0111111);
        check("rst_an_ca", an_ca, 2'b10);
        check("rst_seg_ca", seg_ca, 7'b1000000);
        check("rst_count_ca", count_ca, 8'h00);

        // Up count 00..99 and wrap to 00 with one tc pulse
        reset = 1'b1; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick;
            check($sformatf("up%0d_count", i), count, to_bcd(i % 100));
            check($sformatf("up%0d_tc", i), tc, (i == 100) ? 1'b1 : 1'b0);
        end
        check("up_tc_ca", tc_ca, 1'b1);

        // Table-driven load / down / hold / clamp / priority vectors
        for (int i = 0; i < $size(vecs); i++) begin
            reset    = vecs[i].rst_n;
            en       = vecs[i].en;
            up_dn    = vecs[i].up_dn;
            load     = vecs[i].load;
            load_val = vecs[i].load_val;
            tick;
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
        end

        // Scan and blanking: reset aligns prescaler phase, then loads 07, 00, 50
        reset = 1'b0; en = 1'b0; load = 1'b0;
        tick;
        prev = 8'h00;
        for (int k = 1; k <= 28; k++) begin
            reset    = 1'b1;
            load     = (k == 1) || (k == 13) || (k == 19);
            load_val = (k == 1) ? 8'h07 : (k == 19) ? 8'h50 : 8'h00;
            tick;
            idx      = ((k - 1) / 4) % 2;
            exp_an   = (idx == 0) ? 2'b01 : 2'b10;
            digit    = (idx == 0) ? prev[3:0] : prev[7:4];
            exp_seg  = (idx == 1 && prev[7:4] == 4'd0) ? 7'b0000000 : seg_tab[digit];
            exp_an_n  = ~exp_an;
            exp_seg_n = ~exp_seg;
            check($sformatf("scan%0d_an", k), an, exp_an);
            check($sformatf("scan%0d_seg", k), seg, exp_seg);
            check($sformatf("scan%0d_an_ca", k), an_ca, exp_an_n);
            check($sformatf("scan%0d_seg_ca", k), seg_ca, exp_seg_n);
            if (load) prev = load_val;
        end
        load = 1'b0;

        // Mid-count reset at 57 while counting
        load = 1'b1; load_val = 8'h57; en = 1'b0;
        tick;
        check("mid_load", count, 8'h57);
        load = 1'b0; en = 1'b1; up_dn = 1'b1; reset = 1'b0;
        tick;
        check("mid_rst_count", count, 8'h00);
        check("mid_rst_tc", tc, 1'b0);
        check("mid_rst_an", an, 2'b01);
        check("mid_rst_seg", seg, 7'b0111111);
        check("mid_rst_an_ca", an_ca, 2'b10);
        check("mid_rst_seg_ca", seg_ca, 7'b1000000);
        reset = 1'b1;
        tick;
        check("mid_resume1", count, 8'h01);
        tick;
        check("mid_resume2", count, 8'h02);
        check("mid_resume_tc", tc, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_updown_display
`default_nettype wire
